// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for branch_predictor: lookup, resolved-branch update,
// readiness and optional statistics outputs.
interface branch_predictor_if;
    logic        ready;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        predict_valid;
    logic        predict_taken;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_predicted;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;

    modport master (
        input  ready, predict_valid, predict_taken, stat_updates, stat_mispredicts,
        output lookup_valid, lookup_pc, update_valid, update_pc, update_taken, update_predicted
    );

    modport slave (
        output ready, predict_valid, predict_taken, stat_updates, stat_mispredicts,
        input  lookup_valid, lookup_pc, update_valid, update_pc, update_taken, update_predicted
    );
endinterface

// File: rtl/branch_predictor.sv
// PC-indexed table of 2-bit saturating direction counters, sequentially initialised
// after reset. Optional statistics counters enabled by BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
    parameter int unsigned ENTRIES      = 64,
    parameter int unsigned COUNTER_INIT = 1
) (
    input logic          clk,
    input logic          reset_n,
    branch_predictor_if.slave bp
);
    localparam int unsigned IDX_W    = $clog2(ENTRIES);
    localparam logic [1:0]  INIT_VAL = 2'(COUNTER_INIT);

    typedef enum logic {INIT, RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [1:0]       table_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [1:0]       upd_cur, upd_new, lk_ctr;
    logic             run;
    logic             predict_valid_q, predict_valid_d;
    logic             predict_taken_q, predict_taken_d;

    assign lk_idx  = bp.lookup_pc[IDX_W+1:2];
    assign upd_idx = bp.update_pc[IDX_W+1:2];
    assign run     = (state_q == RUN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == INIT) begin
            init_idx_d = init_idx_q + IDX_W'(1);
            if (init_idx_q == IDX_W'(ENTRIES - 1))
                state_d = RUN;
        end
    end

    always_comb begin
        bp.ready = run;
    end

    always_comb begin
        upd_cur = table_q[upd_idx];
        upd_new = upd_cur;
        if (bp.update_taken) begin
            if (upd_cur != 2'd3) upd_new = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'd0) upd_new = upd_cur - 2'd1;
        end
    end

    // Write-first: a same-cycle update to the looked-up entry is forwarded.
    always_comb begin
        lk_ctr = table_q[lk_idx];
        if (bp.update_valid && (upd_idx == lk_idx))
            lk_ctr = upd_new;
        predict_valid_d = run && bp.lookup_valid;
        predict_taken_d = predict_taken_q;
        if (run && bp.lookup_valid)
            predict_taken_d = lk_ctr[1];
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == INIT)
                table_q[init_idx_q] <= INIT_VAL;
            else if (bp.update_valid)
                table_q[upd_idx] <= upd_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            predict_valid_q <= 1'b0;
            predict_taken_q <= 1'b0;
        end else begin
            predict_valid_q <= predict_valid_d;
            predict_taken_q <= predict_taken_d;
        end
    end

    assign bp.predict_valid = predict_valid_q;
    assign bp.predict_taken = predict_taken_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_upd_q, stat_upd_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        if (run && bp.update_valid) begin
            stat_upd_d = stat_upd_q + 32'd1;
            if (bp.update_predicted != bp.update_taken)
                stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign bp.stat_updates     = stat_upd_q;
    assign bp.stat_mispredicts = stat_mis_q;
`else
    logic unused_stats;
    assign unused_stats        = bp.update_predicted;
    assign bp.stat_updates     = '0;
    assign bp.stat_mispredicts = '0;
`endif

    logic unused_pc;
    assign unused_pc = ^{bp.lookup_pc[31:IDX_W+2], bp.lookup_pc[1:0],
                         bp.update_pc[31:IDX_W+2], bp.update_pc[1:0]};
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=64, COUNTER_INIT=1) against a
// behavioural model of the counter table, init sequence and statistics.
module tb_branch_predictor;
    localparam int N = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    branch_predictor_if bus();

    branch_predictor #(.ENTRIES(64), .COUNTER_INIT(1)) dut (
        .clk(clk), .reset_n(reset_n), .bp(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Behavioural model state
    int     m_tbl [N];
    bit     m_run = 0;
    int     m_init_cnt = 0;
    bit     exp_ready = 0, exp_pv = 0, exp_pt = 0;
    int unsigned m_su = 0, m_sm = 0;
    int unsigned exp_su, exp_sm;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    task automatic stats_exp();
`ifdef BRANCH_PREDICTOR_STATS_EN
        exp_su = m_su;
        exp_sm = m_sm;
`else
        exp_su = 0;
        exp_sm = 0;
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
    task automatic cycle(input bit rst, input bit lv, input logic [31:0] lpc,
                         input bit uv, input logic [31:0] upc, input bit ut, input bit up);
        int i;
        reset_n              = rst;
        bus.lookup_valid     = lv;
        bus.lookup_pc        = lpc;
        bus.update_valid     = uv;
        bus.update_pc        = upc;
        bus.update_taken     = ut;
        bus.update_predicted = up;
        if (!rst) begin
            m_run = 0; m_init_cnt = 0; exp_pv = 0; exp_pt = 0; m_su = 0; m_sm = 0;
            for (int k = 0; k < N; k++) m_tbl[k] = 1;
        end else if (!m_run) begin
            exp_pv = 0;
            m_init_cnt++;
            if (m_init_cnt == N) m_run = 1;
        end else begin
            if (uv) begin
                i = idx_of(upc);
                m_su++;
                if (up != ut) m_sm++;
                m_tbl[i] = ut ? ((m_tbl[i] + 1 > 3) ? 3 : m_tbl[i] + 1)
                              : ((m_tbl[i] - 1 < 0) ? 0 : m_tbl[i] - 1);
            end
            exp_pv = lv;
            if (lv) exp_pt = (m_tbl[idx_of(lpc)] >= 2);
        end
        exp_ready = m_run;
        stats_exp();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();                                   cycle(1, 0, 0, 0, 0, 0, 0);   endtask
    task automatic lookup(input logic [31:0] pc);            cycle(1, 1, pc, 0, 0, 0, 0);  endtask
    task automatic upd(input logic [31:0] pc, input bit t);  cycle(1, 0, 0, 1, pc, t, t);  endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.ready, bus.predict_valid, bus.predict_taken} !== 3'b000)
            $display("FAIL reset_outputs: got %b expected 000", {bus.ready, bus.predict_valid, bus.predict_taken});
        else n_pass++;
        n_checks++;
        if (bus.stat_updates !== 0 || bus.stat_mispredicts !== 0)
            $display("FAIL reset_stats: got %0d/%0d expected 0/0", bus.stat_updates, bus.stat_mispredicts);
        else n_pass++;
        for (int e = 1; e <= N; e++) begin
            cycle(1, 1, 32'h100, 0, 0, 0, 0);
            n_checks++;
            if (bus.ready !== (e == N) || bus.predict_valid !== 1'b0)
                $display("FAIL init_ready edge %0d: got ready=%b pv=%b expected ready=%b pv=0",
                         e, bus.ready, bus.predict_valid, e == N);
            else n_pass++;
        end
        lookup(32'h100);
        n_checks++;
        if (bus.predict_valid !== 1'b1 || bus.predict_taken !== 1'b0)
            $display("FAIL first_lookup: got pv=%b pt=%b expected pv=1 pt=0", bus.predict_valid, bus.predict_taken);
        else n_pass++;
        idle();
        n_checks++;
        if (bus.predict_valid !== 1'b0 || bus.predict_taken !== 1'b0)
            $display("FAIL idle_hold: got pv=%b pt=%b expected pv=0 pt=0", bus.predict_valid, bus.predict_taken);
        else n_pass++;
    endtask

    task automatic test_training();
        bit exp_seq [3] = '{1'b1, 1'b1, 1'b0};
        for (int step = 0; step < 3; step++) begin
            case (step)
                0: begin upd(32'h100, 1); upd(32'h100, 1); end
                1: begin upd(32'h100, 1); upd(32'h100, 1); upd(32'h100, 0); end
                default: begin upd(32'h100, 0); upd(32'h100, 0); end
            endcase
            lookup(32'h100);
            n_checks++;
            if (bus.predict_taken !== exp_seq[step] || bus.predict_taken !== exp_pt)
                $display("FAIL training step %0d: got %b expected %b", step, bus.predict_taken, exp_seq[step]);
            else n_pass++;
        end
    endtask

    task automatic test_aliasing();
        upd(32'h100, 1); upd(32'h100, 1);
        lookup(32'h200);
        n_checks++;
        if (bus.predict_taken !== 1'b1)
            $display("FAIL alias_0x200: got %b expected 1", bus.predict_taken);
        else n_pass++;
        lookup(32'h104);
        n_checks++;
        if (bus.predict_taken !== 1'b0)
            $display("FAIL alias_0x104: got %b expected 0", bus.predict_taken);
        else n_pass++;
        lookup(32'h103);
        n_checks++;
        if (bus.predict_taken !== 1'b1)
            $display("FAIL low_bits_ignored: got %b expected 1", bus.predict_taken);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        cycle(1, 1, 32'h14, 1, 32'h14, 1, 0);
        n_checks++;
        if (bus.predict_valid !== 1'b1 || bus.predict_taken !== 1'b1)
            $display("FAIL forward_same_idx: got pv=%b pt=%b expected pv=1 pt=1", bus.predict_valid, bus.predict_taken);
        else n_pass++;
        cycle(1, 1, 32'h18, 1, 32'h1c, 1, 0);
        n_checks++;
        if (bus.predict_taken !== 1'b0)
            $display("FAIL forward_diff_idx: got %b expected 0", bus.predict_taken);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        upd(32'h100, 1); upd(32'h100, 1); upd(32'h100, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) upd(32'h100, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int e = 1; e <= N; e++) begin
            cycle(1, 1, 32'h100, 1, 32'h100, 1, 0);
            n_checks++;
            if (bus.ready !== (e == N) || bus.predict_valid !== 1'b0)
                $display("FAIL reinit edge %0d: got ready=%b pv=%b expected ready=%b pv=0",
                         e, bus.ready, bus.predict_valid, e == N);
            else n_pass++;
        end
        lookup(32'h100);
        n_checks++;
        if (bus.predict_taken !== 1'b0 || bus.predict_valid !== 1'b1)
            $display("FAIL reinit_lookup: got pv=%b pt=%b expected pv=1 pt=0", bus.predict_valid, bus.predict_taken);
        else n_pass++;
        upd(32'h100, 1);
        lookup(32'h100);
        n_checks++;
        if (bus.predict_taken !== 1'b1)
            $display("FAIL reinit_counter1: got %b expected 1", bus.predict_taken);
        else n_pass++;
    endtask

    task automatic test_stats();
        logic [31:0] pc;
        bit t;
        int unsigned exp_u, exp_m;
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int e = 0; e < N; e++) idle();
        for (int i = 0; i < 10; i++) begin
            pc = $urandom;
            t  = 1'($urandom_range(0, 1));
            cycle(1, 0, 0, 1, pc, t, (i == 2 || i == 5 || i == 8) ? !t : t);
        end
`ifdef BRANCH_PREDICTOR_STATS_EN
        exp_u = 10; exp_m = 3;
`else
        exp_u = 0;  exp_m = 0;
`endif
        n_checks++;
        if (bus.stat_updates !== exp_u || bus.stat_mispredicts !== exp_m)
            $display("FAIL stats: got %0d/%0d expected %0d/%0d", bus.stat_updates, bus.stat_mispredicts, exp_u, exp_m);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] lpc, upc;
        bit lv, uv, ut;
        for (int i = 0; i < 400; i++) begin
            lv  = 1'($urandom_range(0, 1));
            uv  = 1'($urandom_range(0, 1));
            ut  = 1'($urandom_range(0, 1));
            lpc = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 3);
            upc = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 3);
            cycle(1, lv, lpc, uv, upc, ut, 1'($urandom_range(0, 1)));
            n_checks++;
            if (bus.predict_valid !== exp_pv || bus.predict_taken !== exp_pt || bus.ready !== exp_ready)
                $display("FAIL random cyc %0d: got pv=%b pt=%b rdy=%b expected pv=%b pt=%b rdy=%b",
                         i, bus.predict_valid, bus.predict_taken, bus.ready, exp_pv, exp_pt, exp_ready);
            else n_pass++;
            n_checks++;
            if (bus.stat_updates !== exp_su || bus.stat_mispredicts !== exp_sm)
                $display("FAIL random_stats cyc %0d: got %0d/%0d expected %0d/%0d",
                         i, bus.stat_updates, bus.stat_mispredicts, exp_su, exp_sm);
            else n_pass++;
        end
    endtask

    initial begin
        bus.lookup_valid = 0; bus.lookup_pc = 0; bus.update_valid = 0;
        bus.update_pc = 0; bus.update_taken = 0; bus.update_predicted = 0;
        #1;
        test_reset();
        test_training();
        test_aliasing();
        test_forwarding();
        test_reset_midrun();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
